// File: rtl/frame_scanner.sv
// Raster reader: snapshots an 80x135 bitmap in vblank and scans it out as
// 640x480@60 VGA (clk, resetG, frame_in, freeze -> hsync, vsync, blank_n, rgb, frame_start).
module frame_scanner #(
  parameter int          SCALE  = 4,
  parameter int          X_OFF  = 50,
  parameter int          Y_OFF  = 80,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h008,
  parameter int          H_ACT  = 640,
  parameter int          H_FP   = 16,
  parameter int          H_SYNC = 96,
  parameter int          H_BP   = 48,
  parameter int          V_ACT  = 480,
  parameter int          V_FP   = 10,
  parameter int          V_SYNC = 2,
  parameter int          V_BP   = 33
) (
  input  logic                clk,
  input  logic                resetG,
  input  logic [0:79][0:134]  frame_in,
  input  logic                freeze,
  output logic                hsync,
  output logic                vsync,
  output logic                blank_n,
  output logic [11:0]         rgb,
  output logic                frame_start
);

  localparam int SH = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;

  localparam logic [9:0] HA    = 10'(H_ACT);
  localparam logic [9:0] HS0   = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS1   = 10'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [9:0] HMAX  = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA    = 10'(V_ACT);
  localparam logic [9:0] VS0   = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS1   = 10'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [9:0] VMAX  = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VLAST = 10'(V_ACT - 1);
  localparam logic [9:0] XL    = 10'(X_OFF);
  localparam logic [9:0] XH    = 10'(X_OFF + 135 * SCALE);
  localparam logic [9:0] YL    = 10'(Y_OFF);
  localparam logic [9:0] YH    = 10'(Y_OFF + 80 * SCALE);

  logic               pix_en;
  logic [9:0]         hcnt;
  logic [9:0]         vcnt;
  logic [0:79][0:134] shadow;

  logic [9:0] hx;
  logic [9:0] vy;
  logic [7:0] col;
  logic [6:0] row;
  logic       in_win;
  logic       act;
  logic       pix;

  assign hx     = hcnt - XL;
  assign vy     = vcnt - YL;
  assign col    = 8'(hx >> SH);
  assign row    = 7'(vy >> SH);
  assign in_win = (hcnt >= XL) && (hcnt < XH) &&
                  (vcnt >= YL) && (vcnt < YH);
  assign act    = (hcnt < HA) && (vcnt < VA);

  always_comb begin
    pix = 1'b0;
    if (in_win)
      pix = shadow[row][col];
  end

  always_ff @(posedge clk or negedge resetG) begin
    if (!resetG) begin
      pix_en      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
      shadow      <= '0;
    end else begin
      pix_en      <= ~pix_en;
      // one clk wide: cleared again on the following non-pixel edge
      frame_start <= pix_en && (hcnt == '0) && (vcnt == '0);
      if (pix_en) begin
        hsync   <= !((hcnt >= HS0) && (hcnt <= HS1));
        vsync   <= !((vcnt >= VS0) && (vcnt <= VS1));
        blank_n <= act;
        if (!act)
          rgb <= '0;
        else if (pix)
          rgb <= FG_RGB;
        else
          rgb <= BG_RGB;
        // end of last active line: whole-frame copy, so no tearing
        if ((hcnt == HMAX) && (vcnt == VLAST) && !freeze)
          shadow <= frame_in;
        if (hcnt == HMAX) begin
          hcnt <= '0;
          vcnt <= (vcnt == VMAX) ? '0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

endmodule
